pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter NSTAGE, default 5, number of pipeline stages (0=F, 1=D, 2=E, 3=M, ..., NSTAGE-1=W); legal range 5..8.
REQ-002 SHALL have parameter REGW, default 5, register-address width.
REQ-003 SHALL have parameter LDSTG, default 3, stage whose end produces load data; legal range 3..NSTAGE-2.
REQ-004 SHALL have parameter FW = $clog2(NSTAGE), forward-select width.
REQ-005 clk  in  1  sole clock; all state updates on posedge clk.
REQ-006 resetn  in  1  reset, synchronous, active-low.
REQ-007 d_valid  in  1  D stage holds a real instruction.
REQ-008 d_rs, d_rt  in  REGW each  D source register addresses.
REQ-009 d_use_rs, d_use_rt  in  1 each  D instruction actually reads that source.
REQ-010 d_rd  in  REGW  D destination register.
REQ-011 d_regwrite, d_load  in  1 each  D instruction writes d_rd / is a load.
REQ-012 d_branch_taken  in  1  D resolved a taken branch/jump.
REQ-013 i_wait  in  1  instruction bus has not returned F instruction.
REQ-014 m_wait  in  1  data bus busy for instruction in stage LDSTG.
REQ-015 stall  out  NSTAGE  bit k=1: stage k register holds its value this cycle.
REQ-016 bubble  out  NSTAGE  bit k=1: stage k register loads a bubble (invalid) this cycle.
REQ-017 fwd_rs, fwd_rt  out  FW each  0 = regfile value; k = value from stage-k register.
REQ-018 redirect  out  1  fetch takes branch target and discards the F instruction.
REQ-019 stage_valid  out  NSTAGE  per-stage valid bits (bit 0, F, always 1 out of reset).
REQ-020 stall_cnt  out  32  count of cycles with stall[1]=1, saturating.

Function
REQ-021 SHALL keep per stage k>=2: valid, rd, regwrite, load; on non-stalled, non-bubbled advance stage k takes stage k-1 fields; stage 2 takes D inputs, with valid = d_valid.
REQ-022 Match rule: stage k matches source s iff valid, regwrite, rd==s, s!=0, and the corresponding d_use_* =1.
REQ-023 Youngest (lowest k) matching stage SHALL decide; older matches are ignored.
REQ-024 Youngest match in stage 2 -> load-use/ALU hazard (hz=1); load in stage k<=LDSTG -> hz=1.
REQ-025 Otherwise match at stage k (k>=3, and k>LDSTG if load) -> fwd_* = k; no match -> 0; fwd_* SHALL be 0 whenever hz=1 or d_valid=0.
REQ-026 Priority 1, m_wait=1: stall[LDSTG:0]=all 1, bubble[LDSTG+1]=1, other stages advance; redirect=0.
REQ-027 Priority 2, hz=1 and d_valid=1: stall[1:0]=11, bubble[2]=1, stages >=3 advance; redirect=0.
REQ-028 Priority 3, d_branch_taken=1 and d_valid=1: redirect=1, bubble[1]=1 (F instruction discarded), no stall.
REQ-029 Priority 4, i_wait=1: stall[0]=1, bubble[1]=1, stages >=2 advance.
REQ-030 d_branch_taken with i_wait SHALL give redirect=1, bubble[1]=1, stall[0]=0.
REQ-031 stall and bubble SHALL never both be 1 for the same bit; all outputs except stage_valid/stall_cnt combinational.
REQ-032 stall_cnt SHALL increment by 1 each cycle stall[1]=1, holding at 32'hFFFF_FFFF.

Reset
REQ-033 resetn=0 at a posedge SHALL clear all stage valid bits k>=1, rd/regwrite/load fields and stall_cnt to 0, overriding any in-flight stall.
REQ-034 During and directly after reset, with d_valid=0 and m_wait=i_wait=0: stall=0, bubble=0, fwd_*=0, redirect=0, stage_valid=1.

Verification
REQ-035 Load r8 in E, D reads r8 (d_use_rs) -> cycle 1 stall=00011, bubble[2]=1; cycle 2 hz still 1 (load in M=3); cycle 3 fwd_rs=4, stall=0; stall_cnt=2.
REQ-036 ALU write r5 in M, older write r5 in W, D reads r5 -> fwd_rs=3 (youngest), no stall.
REQ-037 D reads r0 with a valid writer of r0 in E -> fwd_rs=0, stall=0.
REQ-038 m_wait=1 for 3 cycles with hazard present -> stall[3:0]=1111, bubble[4]=1 each cycle, redirect suppressed, W valid 0 afterward; stall_cnt+=3.
REQ-039 d_branch_taken=1 with i_wait=1 -> redirect=1, bubble[1]=1, stall[0]=0; next cycle stage_valid[1]=0.
REQ-040 resetn=0 mid m_wait stall -> next cycle stage_valid=1 (bit 0 only), stall_cnt=0; NSTAGE=7, LDSTG=4 rerun of REQ-035 -> fwd_rs=5 after three stall cycles.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the decode stage / memory bus and the pipeline controller.
// Inputs describe the D instruction and bus waits; outputs steer stage registers and operand muxes.
interface pipe_ctrl_if #(
  parameter int NSTAGE = 5,
  parameter int REGW   = 5,
  parameter int FW     = $clog2(NSTAGE)
) ();
  logic              d_valid;
  logic [REGW-1:0]   d_rs;
  logic [REGW-1:0]   d_rt;
  logic              d_use_rs;
  logic              d_use_rt;
  logic [REGW-1:0]   d_rd;
  logic              d_regwrite;
  logic              d_load;
  logic              d_branch_taken;
  logic              i_wait;
  logic              m_wait;
  logic [NSTAGE-1:0] stall;
  logic [NSTAGE-1:0] bubble;
  logic [FW-1:0]     fwd_rs;
  logic [FW-1:0]     fwd_rt;
  logic              redirect;
  logic [NSTAGE-1:0] stage_valid;
  logic [31:0]       stall_cnt;

  modport master (
    output d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_rd, d_regwrite, d_load,
           d_branch_taken, i_wait, m_wait,
    input  stall, bubble, fwd_rs, fwd_rt, redirect, stage_valid, stall_cnt
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_rd, d_regwrite, d_load,
           d_branch_taken, i_wait, m_wait,
    output stall, bubble, fwd_rs, fwd_rt, redirect, stage_valid, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// In-order pipeline hazard controller: per-stage stall/bubble, operand forwarding selects, redirect.
// Control outputs are combinational from the tracked stage state; stage_valid and stall_cnt are registered.
module pipe_ctrl #(
  parameter int NSTAGE = 5,
  parameter int REGW   = 5,
  parameter int LDSTG  = 3,
  parameter int FW     = $clog2(NSTAGE)
) (
  input  logic        clk,
  input  logic        resetn,
  pipe_ctrl_if.slave  bus
);

  logic [NSTAGE-1:1] valid_q, valid_d;
  logic [NSTAGE-1:2] wr_q, wr_d;
  logic [NSTAGE-1:2] ld_q, ld_d;
  logic [REGW-1:0]   rd_q [2:NSTAGE-1];
  logic [REGW-1:0]   rd_d [2:NSTAGE-1];
  logic [31:0]       stall_cnt_q, stall_cnt_d;

  logic [NSTAGE-1:0] stall, bubble;
  logic [FW-1:0]     fwd_rs, fwd_rt;
  logic              redirect;
  logic [FW:0]       res_rs, res_rt;
  logic              hz;

  // Returns {hz, fwd}; only the youngest matching stage is allowed to decide.
  function automatic logic [FW:0] resolve(input logic [REGW-1:0] s, input logic use_s);
    logic          found;
    logic          h;
    logic [FW-1:0] f;
    found = 1'b0;
    h     = 1'b0;
    f     = '0;
    for (int k = 2; k < NSTAGE; k++) begin
      if (!found && use_s && (s != '0) && valid_q[k] && wr_q[k] && (rd_q[k] == s)) begin
        found = 1'b1;
        if ((k == 2) || (ld_q[k] && (k <= LDSTG))) h = 1'b1;
        else                                       f = FW'(k);
      end
    end
    return {h, f};
  endfunction

  always_comb begin
    res_rs   = resolve(bus.d_rs, bus.d_use_rs);
    res_rt   = resolve(bus.d_rt, bus.d_use_rt);
    hz       = res_rs[FW] | res_rt[FW];
    fwd_rs   = '0;
    fwd_rt   = '0;
    if (bus.d_valid && !hz) begin
      fwd_rs = res_rs[FW-1:0];
      fwd_rt = res_rt[FW-1:0];
    end

    stall    = '0;
    bubble   = '0;
    redirect = 1'b0;
    if (bus.m_wait) begin
      stall[LDSTG:0]    = '1;
      bubble[LDSTG+1]   = 1'b1;
    end else if (hz && bus.d_valid) begin
      stall[1:0]        = 2'b11;
      bubble[2]         = 1'b1;
    end else if (bus.d_branch_taken && bus.d_valid) begin
      redirect          = 1'b1;
      bubble[1]         = 1'b1;
    end else if (bus.i_wait) begin
      stall[0]          = 1'b1;
      bubble[1]         = 1'b1;
    end
  end

  always_comb begin
    valid_d     = valid_q;
    wr_d        = wr_q;
    ld_d        = ld_q;
    rd_d        = rd_q;
    stall_cnt_d = stall_cnt_q;

    if (!stall[1]) valid_d[1] = !bubble[1];

    if (bubble[2]) begin
      valid_d[2] = 1'b0;
      wr_d[2]    = 1'b0;
      ld_d[2]    = 1'b0;
      rd_d[2]    = '0;
    end else if (!stall[2]) begin
      valid_d[2] = bus.d_valid;
      wr_d[2]    = bus.d_regwrite;
      ld_d[2]    = bus.d_load;
      rd_d[2]    = bus.d_rd;
    end

    for (int k = 3; k < NSTAGE; k++) begin
      if (bubble[k]) begin
        valid_d[k] = 1'b0;
        wr_d[k]    = 1'b0;
        ld_d[k]    = 1'b0;
        rd_d[k]    = '0;
      end else if (!stall[k]) begin
        valid_d[k] = valid_q[k-1];
        wr_d[k]    = wr_q[k-1];
        ld_d[k]    = ld_q[k-1];
        rd_d[k]    = rd_q[k-1];
      end
    end

    if (stall[1] && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q     <= '0;
      wr_q        <= '0;
      ld_q        <= '0;
      stall_cnt_q <= '0;
      for (int k = 2; k < NSTAGE; k++) rd_q[k] <= '0;
    end else begin
      valid_q     <= valid_d;
      wr_q        <= wr_d;
      ld_q        <= ld_d;
      stall_cnt_q <= stall_cnt_d;
      rd_q        <= rd_d;
    end
  end

  assign bus.stall       = stall;
  assign bus.bubble      = bubble;
  assign bus.fwd_rs      = fwd_rs;
  assign bus.fwd_rt      = fwd_rt;
  assign bus.redirect    = redirect;
  assign bus.stage_valid = {valid_q, 1'b1};
  assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a 5-stage (LDSTG=3) and a 7-stage (LDSTG=4) instance driven in lockstep.
// Expected values are hand-derived per scenario.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.NSTAGE(5), .REGW(5)) ifa ();
  pipe_ctrl_if #(.NSTAGE(7), .REGW(5)) ifb ();

  pipe_ctrl #(.NSTAGE(5), .REGW(5), .LDSTG(3)) dut_a (.clk(clk), .resetn(resetn), .bus(ifa.slave));
  pipe_ctrl #(.NSTAGE(7), .REGW(5), .LDSTG(4)) dut_b (.clk(clk), .resetn(resetn), .bus(ifb.slave));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] rd,
                       input logic wr, input logic ld, input logic br);
    ifa.d_valid = v;  ifa.d_rs = rs;  ifa.d_rt = rt;  ifa.d_use_rs = urs;  ifa.d_use_rt = urt;
    ifa.d_rd = rd;    ifa.d_regwrite = wr;  ifa.d_load = ld;  ifa.d_branch_taken = br;
    ifb.d_valid = v;  ifb.d_rs = rs;  ifb.d_rt = rt;  ifb.d_use_rs = urs;  ifb.d_use_rt = urt;
    ifb.d_rd = rd;    ifb.d_regwrite = wr;  ifb.d_load = ld;  ifb.d_branch_taken = br;
    #1;
  endtask

  task automatic waits(input logic iw, input logic mw);
    ifa.i_wait = iw;  ifa.m_wait = mw;
    ifb.i_wait = iw;  ifb.m_wait = mw;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle();
    waits(1'b0, 1'b0);
    tick();
    resetn = 1'b1;
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    waits(1'b0, 1'b0);
    tick();
    tick();

    // Reset state
    chk("rst_stall",      ifa.stall,       32'h0);
    chk("rst_bubble",     ifa.bubble,      32'h0);
    chk("rst_fwd_rs",     ifa.fwd_rs,      32'h0);
    chk("rst_fwd_rt",     ifa.fwd_rt,      32'h0);
    chk("rst_redirect",   ifa.redirect,    32'h0);
    chk("rst_stage_vld",  ifa.stage_valid, 32'h1);
    chk("rst_stall_cnt",  ifa.stall_cnt,   32'h0);
    resetn = 1'b1;
    #1;
    chk("rel_stage_vld",  ifa.stage_valid, 32'h1);
    tick();
    chk("idle_stage_vld", ifa.stage_valid, 32'h03);

    // Load r8 in E, D reads r8
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    chk("lu_c1_stall",    ifa.stall,   32'h03);
    chk("lu_c1_bubble",   ifa.bubble,  32'h04);
    chk("lu_c1_fwd",      ifa.fwd_rs,  32'h0);
    tick();
    chk("lu_c2_stall",    ifa.stall,   32'h03);
    chk("lu_c2_bubble",   ifa.bubble,  32'h04);
    tick();
    chk("lu_c3_fwd",      ifa.fwd_rs,  32'h4);
    chk("lu_c3_stall",    ifa.stall,   32'h0);
    chk("lu_c3_cnt",      ifa.stall_cnt, 32'd2);
    chk("lu7_c3_stall",   ifb.stall,   32'h03);
    chk("lu7_c3_fwd",     ifb.fwd_rs,  32'h0);
    tick();
    chk("lu7_c4_fwd",     ifb.fwd_rs,  32'h5);
    chk("lu7_c4_stall",   ifb.stall,   32'h0);
    chk("lu7_c4_cnt",     ifb.stall_cnt, 32'd3);

    // ALU writer of r7 in E: rt unused gives no hazard, rt used gives a stall
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd7, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
    chk("rt_unused_stall", ifa.stall,  32'h0);
    drive(1'b1, 5'd0, 5'd7, 1'b0, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
    chk("rt_alu_stall",    ifa.stall,  32'h03);
    chk("rt_alu_fwd",      ifa.fwd_rt, 32'h0);

    // r5 written in M (younger) and in W (older)
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
    chk("young_fwd_rs",   ifa.fwd_rs,  32'h3);
    chk("young_fwd_rt",   ifa.fwd_rt,  32'h3);
    chk("young_stall",    ifa.stall,   32'h0);
    chk("young_bubble",   ifa.bubble,  32'h0);

    // r0 never matches
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    chk("r0_fwd",         ifa.fwd_rs,  32'h0);
    chk("r0_stall",       ifa.stall,   32'h0);

    // m_wait for 3 cycles with a hazard and a taken branch present
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    tick();
    chk("mw_pre_vld",     ifa.stage_valid, 32'h1F);
    drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 1'b1);
    waits(1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      chk("mw_stall",     ifa.stall,    32'h0F);
      chk("mw_bubble",    ifa.bubble,   32'h10);
      chk("mw_redirect",  ifa.redirect, 32'h0);
      tick();
    end
    waits(1'b0, 1'b0);
    idle();
    chk("mw_post_vld",    ifa.stage_valid, 32'h0F);
    chk("mw_cnt",         ifa.stall_cnt,   32'd3);

    // Reset taken in the middle of an m_wait stall
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
    waits(1'b0, 1'b1);
    tick();
    chk("mwr_cnt_pre",    ifa.stall_cnt,   32'd1);
    resetn = 1'b0;
    tick();
    chk("mwr_vld",        ifa.stage_valid, 32'h1);
    chk("mwr_cnt",        ifa.stall_cnt,   32'd0);
    chk("mwr_vld7",       ifb.stage_valid, 32'h1);
    resetn = 1'b1;
    waits(1'b0, 1'b0);

    // i_wait alone, then taken branch with i_wait
    do_reset();
    idle();
    waits(1'b1, 1'b0);
    chk("iw_stall",       ifa.stall,    32'h01);
    chk("iw_bubble",      ifa.bubble,   32'h02);
    chk("iw_redirect",    ifa.redirect, 32'h0);
    waits(1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    waits(1'b1, 1'b0);
    chk("br_redirect",    ifa.redirect, 32'h1);
    chk("br_bubble",      ifa.bubble,   32'h02);
    chk("br_stall",       ifa.stall,    32'h0);
    tick();
    waits(1'b0, 1'b0);
    idle();
    chk("br_next_vld",    ifa.stage_valid, 32'h05);

    // Branch flag on an invalid D slot is ignored
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("br_inv_redirect", ifa.redirect, 32'h0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
